// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-RAM port arbiter.
// Holds the arbiter FSM state encoding and default parameter values.
// No logic; imported by mem_port_arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port RAM between instruction fetch and MEM-stage loads/stores.
// Latency: request seen in IDLE -> RAM access starts next cycle; ack arrives with ram_ready.
// Backpressure: requesters hold until ack; stall terms freeze the pipeline meanwhile.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              PCWrite,
    output logic              IFWrite,
    output logic              mem_stall
);

    localparam int STREAK_W = $clog2(STARVE_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

    // A pending fetch that has already waited STARVE_MAX MEM grants wins over MEM.
    logic fetch_starved;
    assign fetch_starved = if_req && (streak_q == STREAK_MAX);

    // Next-state: arbitrate in IDLE, hold the latched access while busy, drop back on ram_ready.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_req && !fetch_starved) begin
                    state_d     = MEM_BUSY;
                    ram_en_d    = 1'b1;
                    ram_we_d    = mem_we;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d     = IF_BUSY;
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = '0;
                    streak_d    = '0;
                end else begin
                    streak_d = '0;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                // Always return to IDLE after a completed access: no back-to-back chaining.
                if (ram_ready) begin
                    state_d  = IDLE;
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                ram_en_d = 1'b0;
                ram_we_d = 1'b0;
            end
        endcase
    end

    // State and registered RAM-side outputs; async reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    // A flushed fetch (if_req dropped mid-access) completes on the RAM but is never acked.
    assign if_ack    = (state_q == IF_BUSY) && ram_ready && if_req;
    assign mem_ack   = (state_q == MEM_BUSY) && ram_ready;
    assign if_rdata  = ram_rdata;
    assign mem_rdata = ram_rdata;

    assign mem_stall = mem_req && !mem_ack;
    assign PCWrite   = !(if_req && !if_ack) && !mem_stall;
    assign IFWrite   = !(if_req && !if_ack) && !mem_stall;

endmodule
